// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the common data bus between the result producers.
// Each source owns a small FIFO of {entry, value, pc}; one head is granted per
// cycle and broadcast from a registered CDB stage on the following cycle.
// Build option: define CDB_FIXED_PRIO_EN for fixed priority (lowest non-empty
// index wins, no rotating pointer); default build uses round-robin.
module cdb_arbiter #(
    parameter int N_SRC   = 3,
    parameter int DEPTH   = 2,
    parameter int ENTRY_W = 6
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     rdy_in,
    input  logic                     roll_back,
    input  logic [N_SRC-1:0]         src_valid,
    input  logic [N_SRC*ENTRY_W-1:0] src_entry,
    input  logic [N_SRC*32-1:0]      src_value,
    input  logic [N_SRC*32-1:0]      src_pc,
    output logic [N_SRC-1:0]         src_ready,
    output logic                     cdb_valid,
    output logic [ENTRY_W-1:0]       cdb_entry,
    output logic [31:0]              cdb_value,
    output logic [31:0]              cdb_pc,
    output logic [1:0]               cdb_src
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int SEL_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int DATA_W = ENTRY_W + 64;

    logic [DATA_W-1:0] fifo_mem [N_SRC][DEPTH];
    logic [PTR_W-1:0]  wr_ptr   [N_SRC];
    logic [PTR_W-1:0]  rd_ptr   [N_SRC];
    logic [CNT_W-1:0]  count    [N_SRC];

    logic [N_SRC-1:0]  push;
    logic [N_SRC-1:0]  pop;
    logic [N_SRC-1:0]  non_empty;
    logic              active;
    logic              grant_valid;
    logic [SEL_W-1:0]  grant_idx;
    logic [DATA_W-1:0] grant_data;

`ifndef CDB_FIXED_PRIO_EN
    logic [SEL_W-1:0]  rr_ptr;
`endif

    assign active = rdy_in && !roll_back;

    // Per-source acceptance: a FIFO takes a result only while the pipeline runs and it has room.
    always_comb begin
        src_ready = '0;
        non_empty = '0;
        for (int i = 0; i < N_SRC; i++) begin
            src_ready[i] = active && (count[i] < CNT_W'(DEPTH));
            non_empty[i] = (count[i] != '0);
        end
        push = src_valid & src_ready;
    end

    // Pick the first non-empty FIFO, scanning upward from the rotating pointer (or from 0).
    always_comb begin
        int cand;
        cand        = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = 0; off < N_SRC; off++) begin
`ifdef CDB_FIXED_PRIO_EN
            cand = off;
`else
            cand = int'(rr_ptr) + off;
            if (cand >= N_SRC) begin
                cand = cand - N_SRC;
            end
`endif
            if (!grant_valid && non_empty[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = SEL_W'(cand);
            end
        end
    end

    // The granted head is popped only on a running, non-flushing cycle.
    always_comb begin
        pop        = '0;
        grant_data = fifo_mem[grant_idx][rd_ptr[grant_idx]];
        if (grant_valid && active) begin
            pop[grant_idx] = 1'b1;
        end
    end

    // FIFO bookkeeping: flush empties everything, freeze holds, otherwise push/pop independently.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (roll_back) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else if (rdy_in) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
            end
        end
    end

    // FIFO storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) begin
                fifo_mem[i][wr_ptr[i]] <= {src_entry[i*ENTRY_W +: ENTRY_W],
                                           src_value[i*32 +: 32],
                                           src_pc[i*32 +: 32]};
            end
        end
    end

    // Registered CDB stage: this cycle's grant is broadcast for exactly the next cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cdb_valid <= 1'b0;
            cdb_entry <= '0;
            cdb_value <= '0;
            cdb_pc    <= '0;
            cdb_src   <= '0;
        end else if (roll_back) begin
            cdb_valid <= 1'b0;
        end else if (rdy_in) begin
            cdb_valid <= grant_valid;
            if (grant_valid) begin
                cdb_entry <= grant_data[DATA_W-1 -: ENTRY_W];
                cdb_value <= grant_data[63:32];
                cdb_pc    <= grant_data[31:0];
                cdb_src   <= 2'(grant_idx);
            end
        end
    end

`ifndef CDB_FIXED_PRIO_EN
    // Rotating pointer moves just past the last winner so no source starves.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr <= '0;
        end else if (roll_back) begin
            rr_ptr <= '0;
        end else if (rdy_in && grant_valid) begin
            rr_ptr <= (grant_idx == SEL_W'(N_SRC - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter (default round-robin build).
// Accepted pushes are queued per source; each live broadcast pops and compares.
module tb_cdb_arbiter;

    logic        clk_in    = 1'b0;
    logic        rst_n_in  = 1'b0;
    logic        rdy_in    = 1'b0;
    logic        roll_back = 1'b0;
    logic [2:0]  src_valid = '0;
    logic [17:0] src_entry = '0;
    logic [95:0] src_value = '0;
    logic [95:0] src_pc    = '0;
    logic [2:0]  src_ready;
    logic        cdb_valid;
    logic [5:0]  cdb_entry;
    logic [31:0] cdb_value;
    logic [31:0] cdb_pc;
    logic [1:0]  cdb_src;

    typedef struct packed {
        logic [5:0]  entry;
        logic [31:0] value;
        logic [31:0] pc;
    } result_t;

    result_t exp_q [3][$];
    int      pass_cnt  = 0;
    int      total_cnt = 0;
    bit      live_prev = 1'b0;
    int      s0_sent;
    int      s1_sent;
    bit      saw_full;

    cdb_arbiter #(.N_SRC(3), .DEPTH(2), .ENTRY_W(6)) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .rdy_in    (rdy_in),
        .roll_back (roll_back),
        .src_valid (src_valid),
        .src_entry (src_entry),
        .src_value (src_value),
        .src_pc    (src_pc),
        .src_ready (src_ready),
        .cdb_valid (cdb_valid),
        .cdb_entry (cdb_entry),
        .cdb_value (cdb_value),
        .cdb_pc    (cdb_pc),
        .cdb_src   (cdb_src)
    );

    // Free-running clock.
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int i, input bit v, input logic [5:0] e,
                                 input logic [31:0] val, input logic [31:0] p);
        src_valid[i]        = v;
        src_entry[i*6 +: 6] = e;
        src_value[i*32 +: 32] = val;
        src_pc[i*32 +: 32]  = p;
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Track whether each edge was a live cycle; flush and reset discard queued expectations.
    always @(posedge clk_in) begin
        if (!rst_n_in || roll_back) begin
            for (int i = 0; i < 3; i++) exp_q[i].delete();
            live_prev = 1'b0;
        end else begin
            live_prev = rdy_in;
        end
    end

    // Record accepted pushes and score every fresh broadcast against its source's queue.
    always @(negedge clk_in) begin
        result_t r;
        if (rst_n_in) begin
            for (int i = 0; i < 3; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    r.entry = src_entry[i*6 +: 6];
                    r.value = src_value[i*32 +: 32];
                    r.pc    = src_pc[i*32 +: 32];
                    exp_q[i].push_back(r);
                end
            end
            if (cdb_valid && live_prev) begin
                if (cdb_src > 2'd2) begin
                    checkOutput("cdb_src_range", 64'(cdb_src), 64'd2);
                end else if (exp_q[cdb_src].size() == 0) begin
                    checkOutput("stray_bcast", 64'(cdb_valid), 64'd0);
                end else begin
                    r = exp_q[cdb_src].pop_front();
                    checkOutput("sb_entry", 64'(cdb_entry), 64'(r.entry));
                    checkOutput("sb_value", 64'(cdb_value), 64'(r.value));
                    checkOutput("sb_pc",    64'(cdb_pc),    64'(r.pc));
                end
            end
        end
    end

    // Bound the run in case the clocking sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence covering reset, latency, arbitration, backpressure, flush, freeze, async reset.
    initial begin
        #2;
        checkOutput("rst_valid", 64'(cdb_valid), 64'd0);
        checkOutput("rst_entry", 64'(cdb_entry), 64'd0);
        checkOutput("rst_value", 64'(cdb_value), 64'd0);
        checkOutput("rst_pc",    64'(cdb_pc),    64'd0);
        checkOutput("rst_src",   64'(cdb_src),   64'd0);
        step();
        step();
        rst_n_in = 1'b1;
        rdy_in   = 1'b1;
        #1;
        checkOutput("rst_ready", 64'(src_ready), 64'h7);

        // single push, one-bubble latency, broadcast for exactly one cycle
        applyStimulus(0, 1'b1, 6'd5, 32'h1234, 32'h100);
        step();
        applyStimulus(0, 1'b0, 6'd0, 32'h0, 32'h0);
        checkOutput("t2_bubble", 64'(cdb_valid), 64'd0);
        step();
        checkOutput("t2_valid", 64'(cdb_valid), 64'd1);
        checkOutput("t2_entry", 64'(cdb_entry), 64'd5);
        checkOutput("t2_value", 64'(cdb_value), 64'h1234);
        checkOutput("t2_pc",    64'(cdb_pc),    64'h100);
        checkOutput("t2_src",   64'(cdb_src),   64'd0);
        step();
        checkOutput("t2_once", 64'(cdb_valid), 64'd0);

        // flush to bring the rotating pointer back to 0, then all three push together
        roll_back = 1'b1;
        step();
        roll_back = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus(i, 1'b1, 6'(i + 1), 32'hA000_0000 + 32'(i), 32'h300 + 32'(4 * i));
        step();
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 6'd0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("t3_valid", 64'(cdb_valid), 64'd1);
            checkOutput("t3_tag",   64'(cdb_entry), 64'(i + 1));
            checkOutput("t3_src",   64'(cdb_src),   64'(i));
        end
        step();
        checkOutput("t3_idle", 64'(cdb_valid), 64'd0);

        // src0 saturates while src1 pushes three results; src1 must back-pressure after two
        s0_sent  = 0;
        s1_sent  = 0;
        saw_full = 1'b0;
        for (int cyc = 0; cyc < 40 && (s0_sent < 6 || s1_sent < 3); cyc++) begin
            applyStimulus(0, s0_sent < 6, 6'(10 + s0_sent), 32'hCAFE_0000 + 32'(s0_sent),
                          32'h2000 + 32'(4 * s0_sent));
            applyStimulus(1, s1_sent < 3, 6'(20 + s1_sent), 32'hBEEF_0000 + 32'(s1_sent),
                          32'h4000 + 32'(4 * s1_sent));
            @(negedge clk_in);
            if (s1_sent == 2 && src_valid[1] && !src_ready[1]) saw_full = 1'b1;
            if (src_valid[0] && src_ready[0]) s0_sent++;
            if (src_valid[1] && src_ready[1]) s1_sent++;
            @(posedge clk_in);
            #1;
        end
        applyStimulus(0, 1'b0, 6'd0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 6'd0, 32'h0, 32'h0);
        checkOutput("t4_full_seen", 64'(saw_full), 64'd1);
        checkOutput("t4_s1_sent",   64'(s1_sent),  64'd3);
        repeat (8) step();
        checkOutput("t4_drained", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);

        // queue two results, flush before either is broadcast
        applyStimulus(0, 1'b1, 6'd30, 32'h3030, 32'h500);
        applyStimulus(1, 1'b1, 6'd31, 32'h3131, 32'h504);
        step();
        applyStimulus(0, 1'b0, 6'd0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 6'd0, 32'h0, 32'h0);
        roll_back = 1'b1;
        #1;
        checkOutput("t5_ready_rb", 64'(src_ready), 64'd0);
        step();
        roll_back = 1'b0;
        checkOutput("t5_flushed", 64'(cdb_valid), 64'd0);
        #1;
        checkOutput("t5_ready_after", 64'(src_ready), 64'h7);
        repeat (4) begin
            step();
            checkOutput("t5_no_stale", 64'(cdb_valid), 64'd0);
        end

        // freeze while tag 7 is on the bus; resume drains 8 then 9
        applyStimulus(0, 1'b1, 6'd7, 32'h0707, 32'h600);
        applyStimulus(1, 1'b1, 6'd8, 32'h0808, 32'h604);
        applyStimulus(2, 1'b1, 6'd9, 32'h0909, 32'h608);
        step();
        for (int i = 0; i < 3; i++) applyStimulus(i, 1'b0, 6'd0, 32'h0, 32'h0);
        step();
        checkOutput("t6_first_valid", 64'(cdb_valid), 64'd1);
        checkOutput("t6_first_tag",   64'(cdb_entry), 64'd7);
        rdy_in = 1'b0;
        applyStimulus(0, 1'b1, 6'd40, 32'h4040, 32'h700);
        repeat (3) begin
            step();
            checkOutput("t6_hold_valid", 64'(cdb_valid), 64'd1);
            checkOutput("t6_hold_tag",   64'(cdb_entry), 64'd7);
            checkOutput("t6_no_ready",   64'(src_ready), 64'd0);
        end
        rdy_in = 1'b1;
        applyStimulus(0, 1'b0, 6'd0, 32'h0, 32'h0);
        step();
        checkOutput("t6_resume_tag8", 64'(cdb_entry), 64'd8);
        checkOutput("t6_resume_src1", 64'(cdb_src),   64'd1);
        step();
        checkOutput("t6_resume_tag9", 64'(cdb_entry), 64'd9);
        checkOutput("t6_resume_src2", 64'(cdb_src),   64'd2);
        step();
        checkOutput("t6_idle", 64'(cdb_valid), 64'd0);

        // asynchronous reset mid-operation discards the queued result
        applyStimulus(0, 1'b1, 6'd50, 32'h5050, 32'h800);
        applyStimulus(1, 1'b1, 6'd51, 32'h5151, 32'h804);
        step();
        applyStimulus(0, 1'b0, 6'd0, 32'h0, 32'h0);
        applyStimulus(1, 1'b0, 6'd0, 32'h0, 32'h0);
        step();
        checkOutput("t7_pre_tag", 64'(cdb_entry), 64'd50);
        #2;
        rst_n_in = 1'b0;
        #1;
        checkOutput("t7_async_valid", 64'(cdb_valid), 64'd0);
        checkOutput("t7_async_entry", 64'(cdb_entry), 64'd0);
        step();
        rst_n_in = 1'b1;
        repeat (4) begin
            step();
            checkOutput("t7_discarded", 64'(cdb_valid), 64'd0);
        end
        checkOutput("t7_ready", 64'(src_ready), 64'h7);

        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
